// File: rtl/decode_stage_if.sv
// Fetch-to-decode bus: fetched instruction/PC in, decoded fields and handshake out.
interface decode_stage_if #(
  parameter int IWIDTH   = 32,
  parameter int PC_WIDTH = 32
);
  logic [IWIDTH-1:0]   d_i_instr;
  logic [PC_WIDTH-1:0] d_i_pc;
  logic                d_i_ce;
  logic                d_i_stall;
  logic                d_i_flush;
  logic                d_o_stall;
  logic [4:0]          d_o_rs1_raddr;
  logic [4:0]          d_o_rs2_raddr;
  logic [4:0]          d_o_rs1_addr;
  logic [4:0]          d_o_rs2_addr;
  logic [4:0]          d_o_rd_addr;
  logic [31:0]         d_o_imm;
  logic [2:0]          d_o_funct3;
  logic [10:0]         d_o_opcode;
  logic [13:0]         d_o_alu;
  logic                d_o_illegal;
  logic [PC_WIDTH-1:0] d_o_pc;
  logic                d_o_ce;

  modport master (
    output d_i_instr, d_i_pc, d_i_ce, d_i_stall, d_i_flush,
    input  d_o_stall, d_o_rs1_raddr, d_o_rs2_raddr, d_o_rs1_addr, d_o_rs2_addr,
           d_o_rd_addr, d_o_imm, d_o_funct3, d_o_opcode, d_o_alu, d_o_illegal,
           d_o_pc, d_o_ce
  );

  modport slave (
    input  d_i_instr, d_i_pc, d_i_ce, d_i_stall, d_i_flush,
    output d_o_stall, d_o_rs1_raddr, d_o_rs2_raddr, d_o_rs1_addr, d_o_rs2_addr,
           d_o_rd_addr, d_o_imm, d_o_funct3, d_o_opcode, d_o_alu, d_o_illegal,
           d_o_pc, d_o_ce
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: registers the fetched instruction and PC and decodes them
// into register addresses, immediate, one-hot opcode class / ALU op and illegal flag.
module decode_stage #(
  parameter int IWIDTH   = 32,
  parameter int PC_WIDTH = 32
) (
  input logic          d_clk,
  input logic          d_rst,
  decode_stage_if.slave bus
);

  localparam int OP_R = 0, OP_IALU = 1, OP_LOAD = 2, OP_STORE = 3, OP_BRANCH = 4,
                 OP_JAL = 5, OP_JALR = 6, OP_LUI = 7, OP_AUIPC = 8, OP_SYSTEM = 9,
                 OP_FENCE = 10;
  localparam int A_ADD = 0, A_SUB = 1, A_SLT = 2, A_SLTU = 3, A_XOR = 4, A_OR = 5,
                 A_AND = 6, A_SLL = 7, A_SRL = 8, A_SRA = 9, A_EQ = 10, A_NEQ = 11,
                 A_GE = 12, A_GEU = 13;

  logic [IWIDTH-1:0] instr;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [10:0]       opc;
  logic [13:0]       alu;
  logic [31:0]       imm;
  logic              illegal;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;

  assign instr  = bus.d_i_instr;
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign bus.d_o_stall     = bus.d_i_stall;
  assign bus.d_o_rs1_raddr = instr[19:15];
  assign bus.d_o_rs2_raddr = instr[24:20];

  // Shared register/immediate ALU mapping; alt selects SUB/SRA.
  function automatic logic [13:0] arith_op(input logic [2:0] f3, input logic alt);
    logic [13:0] r;
    r = '0;
    case (f3)
      3'b000:  r[alt ? A_SUB : A_ADD] = 1'b1;
      3'b001:  r[A_SLL]  = 1'b1;
      3'b010:  r[A_SLT]  = 1'b1;
      3'b011:  r[A_SLTU] = 1'b1;
      3'b100:  r[A_XOR]  = 1'b1;
      3'b101:  r[alt ? A_SRA : A_SRL] = 1'b1;
      3'b110:  r[A_OR]   = 1'b1;
      default: r[A_AND]  = 1'b1;
    endcase
    return r;
  endfunction

  always_comb begin
    opc     = '0;
    alu     = '0;
    imm     = '0;
    illegal = 1'b0;
    rs1     = instr[19:15];
    rs2     = instr[24:20];
    rd      = instr[11:7];

    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (instr[6:0])
        7'b0110011: begin
          opc[OP_R] = 1'b1;
          if (funct7 == 7'b0000000)
            alu = arith_op(funct3, 1'b0);
          else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
            alu = arith_op(funct3, 1'b1);
          else
            illegal = 1'b1;
        end
        7'b0010011: begin
          opc[OP_IALU] = 1'b1;
          alu = arith_op(funct3, (funct3 == 3'b101) && instr[30]);
          imm = {{20{instr[31]}}, instr[31:20]};
        end
        7'b0000011: begin
          opc[OP_LOAD] = 1'b1;
          alu[A_ADD]   = 1'b1;
          imm = {{20{instr[31]}}, instr[31:20]};
        end
        7'b0100011: begin
          opc[OP_STORE] = 1'b1;
          alu[A_ADD]    = 1'b1;
          imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        end
        7'b1100011: begin
          opc[OP_BRANCH] = 1'b1;
          imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
          case (funct3)
            3'b000:  alu[A_EQ]   = 1'b1;
            3'b001:  alu[A_NEQ]  = 1'b1;
            3'b100:  alu[A_SLT]  = 1'b1;
            3'b101:  alu[A_GE]   = 1'b1;
            3'b110:  alu[A_SLTU] = 1'b1;
            3'b111:  alu[A_GEU]  = 1'b1;
            default: illegal     = 1'b1;
          endcase
        end
        7'b1101111: begin
          opc[OP_JAL] = 1'b1;
          alu[A_ADD]  = 1'b1;
          imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        end
        7'b1100111: begin
          opc[OP_JALR] = 1'b1;
          alu[A_ADD]   = 1'b1;
          imm = {{20{instr[31]}}, instr[31:20]};
        end
        7'b0110111: begin
          opc[OP_LUI] = 1'b1;
          alu[A_ADD]  = 1'b1;
          imm = {instr[31:12], 12'b0};
        end
        7'b0010111: begin
          opc[OP_AUIPC] = 1'b1;
          alu[A_ADD]    = 1'b1;
          imm = {instr[31:12], 12'b0};
        end
        7'b1110011: begin
          opc[OP_SYSTEM] = 1'b1;
          imm = {{20{instr[31]}}, instr[31:20]};
        end
        7'b0001111: opc[OP_FENCE] = 1'b1;
        default:    illegal = 1'b1;
      endcase
    end

    if (illegal) begin
      opc = '0;
      alu = '0;
      imm = '0;
    end

    if (!(opc[OP_R] || opc[OP_STORE] || opc[OP_BRANCH])) rs2 = '0;
    if (opc[OP_LUI] || opc[OP_AUIPC] || opc[OP_JAL])     rs1 = '0;
    if (opc[OP_STORE] || opc[OP_BRANCH])                 rd  = '0;
  end

  // Flush outranks stall so a redirect always kills the held instruction.
  always_ff @(posedge d_clk) begin
    if (d_rst) begin
      bus.d_o_rs1_addr <= '0;
      bus.d_o_rs2_addr <= '0;
      bus.d_o_rd_addr  <= '0;
      bus.d_o_imm      <= '0;
      bus.d_o_funct3   <= '0;
      bus.d_o_opcode   <= '0;
      bus.d_o_alu      <= '0;
      bus.d_o_illegal  <= 1'b0;
      bus.d_o_pc       <= '0;
      bus.d_o_ce       <= 1'b0;
    end else if (bus.d_i_flush) begin
      bus.d_o_ce      <= 1'b0;
      bus.d_o_illegal <= 1'b0;
    end else if (!bus.d_i_stall) begin
      bus.d_o_rs1_addr <= rs1;
      bus.d_o_rs2_addr <= rs2;
      bus.d_o_rd_addr  <= rd;
      bus.d_o_imm      <= imm;
      bus.d_o_funct3   <= funct3;
      bus.d_o_opcode   <= opc;
      bus.d_o_alu      <= alu;
      bus.d_o_illegal  <= illegal;
      bus.d_o_pc       <= bus.d_i_pc[PC_WIDTH-1:0];
      bus.d_o_ce       <= bus.d_i_ce;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expected decodes.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  decode_stage_if #(.IWIDTH(32), .PC_WIDTH(32)) bus ();

  decode_stage #(.IWIDTH(32), .PC_WIDTH(32)) dut (
    .d_clk (clk),
    .d_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic ce,
                       input logic stall, input logic flush);
    bus.d_i_instr = instr;
    bus.d_i_pc    = pc;
    bus.d_i_ce    = ce;
    bus.d_i_stall = stall;
    bus.d_i_flush = flush;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h00500093, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
    step();
    step();
    total_cnt++; if (bus.d_o_ce !== 1'b0) $display("FAIL reset_ce got %0h exp 0", bus.d_o_ce); else pass_cnt++;
    total_cnt++; if (bus.d_o_rd_addr !== 5'd0) $display("FAIL reset_rd got %0h exp 0", bus.d_o_rd_addr); else pass_cnt++;
    total_cnt++; if (bus.d_o_imm !== 32'd0) $display("FAIL reset_imm got %0h exp 0", bus.d_o_imm); else pass_cnt++;
    total_cnt++; if (bus.d_o_opcode !== 11'd0) $display("FAIL reset_opcode got %0h exp 0", bus.d_o_opcode); else pass_cnt++;
    total_cnt++; if (bus.d_o_alu !== 14'd0) $display("FAIL reset_alu got %0h exp 0", bus.d_o_alu); else pass_cnt++;
    total_cnt++; if (bus.d_o_pc !== 32'd0) $display("FAIL reset_pc got %0h exp 0", bus.d_o_pc); else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++; if (bus.d_o_ce !== 1'b1) $display("FAIL addi_ce got %0h exp 1", bus.d_o_ce); else pass_cnt++;
    total_cnt++; if (bus.d_o_rd_addr !== 5'd1) $display("FAIL addi_rd got %0h exp 1", bus.d_o_rd_addr); else pass_cnt++;
    total_cnt++; if (bus.d_o_rs1_addr !== 5'd0) $display("FAIL addi_rs1 got %0h exp 0", bus.d_o_rs1_addr); else pass_cnt++;
    total_cnt++; if (bus.d_o_rs2_addr !== 5'd0) $display("FAIL addi_rs2 got %0h exp 0", bus.d_o_rs2_addr); else pass_cnt++;
    total_cnt++; if (bus.d_o_imm !== 32'd5) $display("FAIL addi_imm got %0h exp 5", bus.d_o_imm); else pass_cnt++;
    total_cnt++; if (bus.d_o_opcode !== 11'h002) $display("FAIL addi_opcode got %0h exp 002", bus.d_o_opcode); else pass_cnt++;
    total_cnt++; if (bus.d_o_alu !== 14'h0001) $display("FAIL addi_alu got %0h exp 0001", bus.d_o_alu); else pass_cnt++;
    total_cnt++; if (bus.d_o_pc !== 32'h100) $display("FAIL addi_pc got %0h exp 100", bus.d_o_pc); else pass_cnt++;
  endtask

  task automatic test_rtype();
    drive(32'h402081B3, 32'h0000_0104, 1'b1, 1'b0, 1'b0);
    #1;
    total_cnt++; if (bus.d_o_rs1_raddr !== 5'd1) $display("FAIL sub_raddr1 got %0h exp 1", bus.d_o_rs1_raddr); else pass_cnt++;
    total_cnt++; if (bus.d_o_rs2_raddr !== 5'd2) $display("FAIL sub_raddr2 got %0h exp 2", bus.d_o_rs2_raddr); else pass_cnt++;
    step();
    total_cnt++; if (bus.d_o_rs1_addr !== 5'd1) $display("FAIL sub_rs1 got %0h exp 1", bus.d_o_rs1_addr); else pass_cnt++;
    total_cnt++; if (bus.d_o_rs2_addr !== 5'd2) $display("FAIL sub_rs2 got %0h exp 2", bus.d_o_rs2_addr); else pass_cnt++;
    total_cnt++; if (bus.d_o_rd_addr !== 5'd3) $display("FAIL sub_rd got %0h exp 3", bus.d_o_rd_addr); else pass_cnt++;
    total_cnt++; if (bus.d_o_imm !== 32'd0) $display("FAIL sub_imm got %0h exp 0", bus.d_o_imm); else pass_cnt++;
    total_cnt++; if (bus.d_o_opcode !== 11'h001) $display("FAIL sub_opcode got %0h exp 001", bus.d_o_opcode); else pass_cnt++;
    total_cnt++; if (bus.d_o_alu !== 14'h0002) $display("FAIL sub_alu got %0h exp 0002", bus.d_o_alu); else pass_cnt++;
  endtask

  task automatic test_branch_lui();
    drive(32'hFE208EE3, 32'h0000_0108, 1'b1, 1'b0, 1'b0);
    step();
    total_cnt++; if (bus.d_o_imm !== 32'hFFFFFFFC) $display("FAIL beq_imm got %0h exp fffffffc", bus.d_o_imm); else pass_cnt++;
    total_cnt++; if (bus.d_o_rd_addr !== 5'd0) $display("FAIL beq_rd got %0h exp 0", bus.d_o_rd_addr); else pass_cnt++;
    total_cnt++; if (bus.d_o_rs2_addr !== 5'd2) $display("FAIL beq_rs2 got %0h exp 2", bus.d_o_rs2_addr); else pass_cnt++;
    total_cnt++; if (bus.d_o_opcode !== 11'h010) $display("FAIL beq_opcode got %0h exp 010", bus.d_o_opcode); else pass_cnt++;
    total_cnt++; if (bus.d_o_alu !== 14'h0400) $display("FAIL beq_alu got %0h exp 0400", bus.d_o_alu); else pass_cnt++;
    drive(32'h123450B7, 32'h0000_010C, 1'b1, 1'b0, 1'b0);
    step();
    total_cnt++; if (bus.d_o_imm !== 32'h12345000) $display("FAIL lui_imm got %0h exp 12345000", bus.d_o_imm); else pass_cnt++;
    total_cnt++; if (bus.d_o_rs1_addr !== 5'd0) $display("FAIL lui_rs1 got %0h exp 0", bus.d_o_rs1_addr); else pass_cnt++;
    total_cnt++; if (bus.d_o_opcode !== 11'h080) $display("FAIL lui_opcode got %0h exp 080", bus.d_o_opcode); else pass_cnt++;
    drive(32'h4030D093, 32'h0000_0110, 1'b1, 1'b0, 1'b0);
    step();
    total_cnt++; if (bus.d_o_alu !== 14'h0200) $display("FAIL srai_alu got %0h exp 0200", bus.d_o_alu); else pass_cnt++;
    total_cnt++; if (bus.d_o_imm !== 32'h403) $display("FAIL srai_imm got %0h exp 403", bus.d_o_imm); else pass_cnt++;
    drive(32'h0020A223, 32'h0000_0114, 1'b1, 1'b0, 1'b0);
    step();
    total_cnt++; if (bus.d_o_imm !== 32'd4) $display("FAIL sw_imm got %0h exp 4", bus.d_o_imm); else pass_cnt++;
    total_cnt++; if (bus.d_o_rd_addr !== 5'd0) $display("FAIL sw_rd got %0h exp 0", bus.d_o_rd_addr); else pass_cnt++;
    total_cnt++; if (bus.d_o_opcode !== 11'h008) $display("FAIL sw_opcode got %0h exp 008", bus.d_o_opcode); else pass_cnt++;
    drive(32'h008000EF, 32'h0000_0118, 1'b1, 1'b0, 1'b0);
    step();
    total_cnt++; if (bus.d_o_imm !== 32'd8) $display("FAIL jal_imm got %0h exp 8", bus.d_o_imm); else pass_cnt++;
    total_cnt++; if (bus.d_o_opcode !== 11'h020) $display("FAIL jal_opcode got %0h exp 020", bus.d_o_opcode); else pass_cnt++;
  endtask

  task automatic test_stall();
    drive(32'h00500093, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'h402081B3, 32'h0000_0204, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (bus.d_o_stall !== 1'b1) $display("FAIL stall_out[%0d] got %0h exp 1", i, bus.d_o_stall); else pass_cnt++;
      total_cnt++; if (bus.d_o_rd_addr !== 5'd1 || bus.d_o_imm !== 32'd5 || bus.d_o_alu !== 14'h0001 || bus.d_o_pc !== 32'h200)
        $display("FAIL stall_hold[%0d] got rd=%0h imm=%0h alu=%0h pc=%0h exp rd=1 imm=5 alu=1 pc=200",
                 i, bus.d_o_rd_addr, bus.d_o_imm, bus.d_o_alu, bus.d_o_pc);
      else pass_cnt++;
    end
    bus.d_i_stall = 1'b0;
    step();
    total_cnt++; if (bus.d_o_alu !== 14'h0002 || bus.d_o_rd_addr !== 5'd3 || bus.d_o_pc !== 32'h204)
      $display("FAIL stall_release got alu=%0h rd=%0h pc=%0h exp alu=2 rd=3 pc=204", bus.d_o_alu, bus.d_o_rd_addr, bus.d_o_pc);
    else pass_cnt++;
    bus.d_i_ce = 1'b0;
    step();
    total_cnt++; if (bus.d_o_ce !== 1'b0) $display("FAIL bubble_ce got %0h exp 0", bus.d_o_ce); else pass_cnt++;
  endtask

  task automatic test_flush();
    drive(32'h00500093, 32'h0000_0300, 1'b1, 1'b0, 1'b1);
    step();
    total_cnt++; if (bus.d_o_ce !== 1'b0) $display("FAIL flush_ce got %0h exp 0", bus.d_o_ce); else pass_cnt++;
    drive(32'h00500093, 32'h0000_0304, 1'b1, 1'b0, 1'b0);
    step();
    total_cnt++; if (bus.d_o_ce !== 1'b1) $display("FAIL preflush_ce got %0h exp 1", bus.d_o_ce); else pass_cnt++;
    drive(32'h00500093, 32'h0000_0308, 1'b1, 1'b1, 1'b1);
    step();
    total_cnt++; if (bus.d_o_ce !== 1'b0) $display("FAIL flush_stall_ce got %0h exp 0", bus.d_o_ce); else pass_cnt++;
  endtask

  task automatic test_illegal();
    drive(32'h00000000, 32'h0000_0400, 1'b1, 1'b0, 1'b0);
    step();
    total_cnt++; if (bus.d_o_ce !== 1'b1 || bus.d_o_illegal !== 1'b1)
      $display("FAIL ill_zero got ce=%0h ill=%0h exp ce=1 ill=1", bus.d_o_ce, bus.d_o_illegal); else pass_cnt++;
    total_cnt++; if (bus.d_o_opcode !== 11'd0 || bus.d_o_alu !== 14'd0)
      $display("FAIL ill_zero_class got op=%0h alu=%0h exp 0 0", bus.d_o_opcode, bus.d_o_alu); else pass_cnt++;
    drive(32'h0000A063, 32'h0000_0404, 1'b1, 1'b0, 1'b0);
    step();
    total_cnt++; if (bus.d_o_ce !== 1'b1 || bus.d_o_illegal !== 1'b1)
      $display("FAIL ill_br got ce=%0h ill=%0h exp ce=1 ill=1", bus.d_o_ce, bus.d_o_illegal); else pass_cnt++;
    total_cnt++; if (bus.d_o_opcode !== 11'd0 || bus.d_o_alu !== 14'd0)
      $display("FAIL ill_br_class got op=%0h alu=%0h exp 0 0", bus.d_o_opcode, bus.d_o_alu); else pass_cnt++;
    drive(32'h0220C1B3, 32'h0000_0408, 1'b1, 1'b0, 1'b0);
    step();
    total_cnt++; if (bus.d_o_illegal !== 1'b1) $display("FAIL ill_f7 got %0h exp 1", bus.d_o_illegal); else pass_cnt++;
    rst = 1'b1;
    drive(32'h00500093, 32'h0000_040C, 1'b1, 1'b0, 1'b0);
    step();
    total_cnt++; if (bus.d_o_ce !== 1'b0 || bus.d_o_illegal !== 1'b0)
      $display("FAIL midreset got ce=%0h ill=%0h exp 0 0", bus.d_o_ce, bus.d_o_illegal); else pass_cnt++;
    rst = 1'b0;
  endtask

  initial begin
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    test_reset();
    test_rtype();
    test_branch_lui();
    test_stall();
    test_flush();
    test_illegal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of instruction fetch.
- Registers the fetched RV32I instruction word and its PC, decodes it into register addresses, a sign-extended immediate, a one-hot opcode class, a one-hot ALU operation and an illegal-instruction flag.
- Propagates backpressure to fetch and discards its contents on a PC redirect.

Parameters:
- IWIDTH, 32, instruction width.
- PC_WIDTH, 32, PC width.

Ports:
- d_clk  input  1  clock; all state on rising edge.
- d_rst  input  1  reset; synchronous, active-high.
- d_i_instr  input  IWIDTH  instruction from fetch.
- d_i_pc  input  PC_WIDTH  PC of d_i_instr.
- d_i_ce  input  1  d_i_instr/d_i_pc valid.
- d_i_stall  input  1  downstream stall request.
- d_i_flush  input  1  PC redirect (change_pc); kill the held instruction.
- d_o_stall  output  1  stall request to fetch.
- d_o_rs1_raddr  output  5  combinational rs1 = d_i_instr[19:15], for synchronous regfile read.
- d_o_rs2_raddr  output  5  combinational rs2 = d_i_instr[24:20].
- d_o_rs1_addr  output  5  registered rs1.
- d_o_rs2_addr  output  5  registered rs2.
- d_o_rd_addr  output  5  registered rd.
- d_o_imm  output  32  registered immediate.
- d_o_funct3  output  3  registered instr[14:12].
- d_o_opcode  output  11  one-hot: [0]R [1]I-alu [2]load [3]store [4]branch [5]jal [6]jalr [7]lui [8]auipc [9]system [10]fence.
- d_o_alu  output  14  one-hot: [0]ADD [1]SUB [2]SLT [3]SLTU [4]XOR [5]OR [6]AND [7]SLL [8]SRL [9]SRA [10]EQ [11]NEQ [12]GE [13]GEU.
- d_o_illegal  output  1  illegal encoding.
- d_o_pc  output  PC_WIDTH  registered PC.
- d_o_ce  output  1  outputs valid.

Behaviour:
- Reset: every registered output is 0 on the next edge, including mid-operation. The combinational raddr ports still follow d_i_instr.
- d_o_stall = d_i_stall. Fetch holds d_i_* while d_o_stall is high.
- Edge priority (highest first):
  - d_rst: clear all registered outputs.
  - d_i_flush: d_o_ce <= 0, d_o_illegal <= 0; other fields don't-care. Flush overrides stall.
  - d_i_stall: hold all registered outputs.
  - Otherwise: load decode of d_i_*, and d_o_ce <= d_i_ce.
- Latency: 1 cycle from d_i_ce to d_o_ce.
- d_i_ce = 0 without stall or flush: d_o_ce <= 0 (bubble).
- Immediates (sign bit instr[31]):
  - I (I-alu, load, jalr, system): sext(instr[31:20]).
  - S: sext({[31:25],[11:7]}).
  - B: sext({[31],[7],[30:25],[11:8],0}).
  - U (lui, auipc): {[31:12],12'b0}.
  - J: sext({[31],[19:12],[20],[30:21],0}).
  - R, fence: 0.
- Address zeroing:
  - rs2 = 0 unless R/store/branch.
  - rs1 = 0 for lui/auipc/jal.
  - rd = 0 for store/branch.
- ALU select:
  - R: funct3 000 gives SUB if instr[30] else ADD; 101 gives SRA if instr[30] else SRL; 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - I-alu: same mapping, except funct3 000 is always ADD.
  - branch: 000 EQ, 001 NEQ, 100 SLT, 101 GE, 110 SLTU, 111 GEU.
  - load/store/jal/jalr/lui/auipc: ADD.
  - system/fence: all zero.
- Illegal, with d_o_opcode = 0 and d_o_alu = 0 and the instruction still valid (d_o_ce = d_i_ce):
  - instr[1:0] != 11;
  - unknown opcode;
  - branch funct3 010/011;
  - R funct7 not in {0000000, 0100000}, or 0100000 with funct3 not 000/101.

Test Plan:
- Reset: assert d_rst for 2 cycles with d_i_ce = 1 -> all registered outputs 0; release, then 0x00500093 (addi x1,x0,5) -> next cycle d_o_ce=1, rd=1, rs1=0, rs2=0, imm=5, opcode[1], alu[0].
- R-type: 0x402081B3 (sub x3,x1,x2) -> rs1=1, rs2=2, rd=3, imm=0, opcode[0], alu[1]; d_o_rs1_raddr=1 in the same cycle as input.
- Branch: 0xFE208EE3 (beq x1,x2,-4) -> imm=0xFFFFFFFC, rd=0, opcode[4], alu[10]; 0x123450B7 (lui x1) -> imm=0x12345000, rs1=0.
- Stall: decode 0x00500093, then raise d_i_stall for 3 cycles while presenting 0x402081B3 -> outputs frozen, d_o_stall=1; drop stall -> SUB decode appears next cycle.
- Flush: d_i_ce=1 with d_i_flush=1, repeated with d_i_stall=1 -> d_o_ce=0 the next cycle in both cases.
- Illegal: 0x00000000 and 0x0000A063 (branch funct3 010) -> d_o_ce=1, d_o_illegal=1, opcode=0, alu=0; mid-stream reset -> d_o_ce=0 on the next edge.
